// File: rtl/tagged_seq_divider_pkg.sv
// rtl/tagged_seq_divider_pkg.sv - shared state encodings and defaults for the tagged sequential divider
package tagged_seq_divider_pkg;

  // One-hot encodings; the dispatching controller decodes these same values.
  typedef enum logic [2:0] {
    QI = 3'b001,
    QC = 3'b010,
    QD = 3'b100
  } div_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAG_W = 3;

endpackage

// File: rtl/tagged_seq_divider.sv
// rtl/tagged_seq_divider.sv - repeated-subtraction divider with ROB tag pass-through and done/ack hold
module tagged_seq_divider
  import tagged_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic [TAG_W-1:0] tag_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_by_zero,
  output logic [2:0]       state
);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] diff;
  logic             rem_ge_div;

  // Single subtractor; its borrow bit doubles as the remainder>=divisor compare
  always_comb begin
    sub_full   = {1'b0, remainder} - {1'b0, divisor_q};
    diff       = sub_full[WIDTH-1:0];
    rem_ge_div = ~sub_full[WIDTH];
  end

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= QI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only matters in Qi, ack only in Qd
  always_comb begin
    state_d = state_q;
    case (state_q)
      QI: begin
        if (start) begin
          state_d = (yin == '0) ? QD : QC;
        end
      end
      QC: begin
        if (!rem_ge_div) begin
          state_d = QD;
        end
      end
      QD: begin
        if (ack) begin
          state_d = QI;
        end
      end
      default: state_d = QI;
    endcase
  end

  // Datapath: capture on dispatch, subtract-and-count while computing, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      tag_out     <= '0;
      div_by_zero <= 1'b0;
      divisor_q   <= '0;
    end else begin
      case (state_q)
        QI: begin
          if (start) begin
            remainder <= xin;
            tag_out   <= tag_in;
            if (yin == '0) begin
              quotient    <= '1;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= '0;
              divisor_q   <= yin;
              div_by_zero <= 1'b0;
            end
          end
        end
        QC: begin
          if (rem_ge_div) begin
            remainder <= diff;
            quotient  <= quotient + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Expose the registered one-hot state to the controller
  always_comb begin
    state = state_q;
  end

endmodule

// File: tb/tb_tagged_seq_divider.sv
// tb/tb_tagged_seq_divider.sv - scoreboard bench for tagged_seq_divider
module tb_tagged_seq_divider;

  localparam logic [2:0] S_QI = 3'b001;
  localparam logic [2:0] S_QC = 3'b010;
  localparam logic [2:0] S_QD = 3'b100;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ack;
  logic [7:0] xin;
  logic [7:0] yin;
  logic [2:0] tag_in;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic [2:0] tag_out;
  logic       div_by_zero;
  logic [2:0] state;

  typedef struct {
    int q;
    int r;
    int tag;
    int dbz;
    int lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  logic [2:0] prev_state = 3'b000;

  tagged_seq_divider dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ack(ack),
    .xin(xin),
    .yin(yin),
    .tag_in(tag_in),
    .quotient(quotient),
    .remainder(remainder),
    .tag_out(tag_out),
    .div_by_zero(div_by_zero),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on every entry into Qd, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (!rst && state == S_QD && prev_state != S_QD) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("tag_out", int'(tag_out), e.tag);
        check("div_by_zero", int'(div_by_zero), e.dbz);
        check("latency_edges", cyc - start_cyc, e.lat);
      end
    end
    prev_state = state;
  end

  // Caller is at a negedge; start is sampled on the following posedge
  task automatic dispatch(input int x, input int y, input int t, input int eq, input int er);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.tag = t;
    e.dbz = (y == 0) ? 1 : 0;
    e.lat = (y == 0) ? 1 : eq + 2;
    sb.push_back(e);
    start     = 1'b1;
    xin       = 8'(x);
    yin       = 8'(y);
    tag_in    = 3'(t);
    start_cyc = cyc;
    @(negedge clk);
    start  = 1'b0;
    xin    = 8'hA5;
    yin    = 8'h5A;
    tag_in = 3'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (state != S_QD && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    if (state != S_QD) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    ack    = 1'b0;
    xin    = 8'd0;
    yin    = 8'd0;
    tag_in = 3'd0;
    #1;
    check("reset_state", int'(state), int'(S_QI));
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_tag", int'(tag_out), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic 9/3, then hold ten cycles without ack
    dispatch(9, 3, 5, 3, 0);
    check("basic_in_qc", int'(state), int'(S_QC));
    wait_done("basic", 20);
    repeat (10) @(negedge clk);
    check("basic_hold_state", int'(state), int'(S_QD));
    check("basic_hold_q", int'(quotient), 3);
    ack_pulse();
    check("basic_ack_qi", int'(state), int'(S_QI));
    check("basic_keep_q", int'(quotient), 3);
    check("basic_keep_tag", int'(tag_out), 5);

    // Divisor larger than dividend
    dispatch(7, 10, 2, 0, 7);
    wait_done("small", 10);
    ack_pulse();

    // Divide by zero skips Qc
    dispatch(200, 0, 7, 255, 200);
    check("dbz_direct_qd", int'(state), int'(S_QD));
    ack_pulse();

    // ack in Qi is ignored
    ack_pulse();
    check("ack_in_qi", int'(state), int'(S_QI));
    check("ack_in_qi_q", int'(quotient), 255);

    // Worst case with stray start/ack during Qc and Qd
    dispatch(255, 1, 6, 255, 0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    xin   = 8'd3;
    yin   = 8'd0;
    tag_in = 3'd1;
    @(negedge clk);
    start = 1'b0;
    ack_pulse();
    check("worst_still_qc", int'(state), int'(S_QC));
    wait_done("worst", 300);
    start  = 1'b1;
    xin    = 8'd4;
    yin    = 8'd2;
    tag_in = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("start_in_qd_state", int'(state), int'(S_QD));
    check("start_in_qd_q", int'(quotient), 255);
    check("start_in_qd_tag", int'(tag_out), 6);
    ack_pulse();

    // Back-to-back: ack then start in the very next cycle
    @(negedge clk);
    dispatch(100, 7, 1, 14, 2);
    wait_done("b2b_first", 30);
    ack_pulse();
    check("b2b_qi", int'(state), int'(S_QI));
    dispatch(50, 6, 4, 8, 2);
    wait_done("b2b_second", 30);
    ack_pulse();

    // Asynchronous reset during Qc abandons the operation
    dispatch(200, 3, 0, 66, 2);
    repeat (5) @(negedge clk);
    check("pre_reset_qc", int'(state), int'(S_QC));
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), int'(S_QI));
    check("async_rst_q", int'(quotient), 0);
    check("async_rst_r", int'(remainder), 0);
    check("async_rst_tag", int'(tag_out), 0);
    check("async_rst_dbz", int'(div_by_zero), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dispatch(12, 5, 3, 2, 2);
    wait_done("post_reset", 10);
    ack_pulse();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
